fma_issue_arbiter: RTL and testbench

- Shares one combinational fused multiply-add datapath (A*B + C on 8-bit exponents and 24-bit mantissas) between NREQ requesters.
- Arbitrates round-robin and registers the granted operands to drive the datapath.
- Carries the datapath result through LAT result-register stages, tagged with the requester index.
- Returns each result on a single valid/ready port with full-pipeline backpressure.

---
 rtl/fma_issue_arbiter_if.sv | 36 +++
 rtl/fma_issue_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_fma_issue_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fma_issue_arbiter_if.sv
// ---------------------------------------------------------------------------
// fma_issue_arbiter_if
// Purpose : Groups the requester-side and result-side handshakes of the
//           FMA issue arbiter into one bundle.
// Signals : req_valid [NREQ]     per-requester request valid
//           req_op    [NREQ*96]  per-requester operands {expA,expB,expC,manA,manB,manC}
//           req_ready [NREQ]     per-requester accept (one-hot or zero)
//           res_valid / res_ready  result handshake
//           res_tag   [TW]       owning requester index
//           res_exp   [8], res_man [24]  result payload
// Modports: master = requesters + result consumer, slave = arbiter.
// ---------------------------------------------------------------------------
interface fma_issue_arbiter_if #(
  parameter int NREQ = 4
) ();
  localparam int TW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*96-1:0] req_op;
  logic [NREQ-1:0]    req_ready;
  logic               res_valid;
  logic [TW-1:0]      res_tag;
  logic [7:0]         res_exp;
  logic [23:0]        res_man;
  logic               res_ready;

  modport master (
    output req_valid, req_op, res_ready,
    input  req_ready, res_valid, res_tag, res_exp, res_man
  );

  modport slave (
    input  req_valid, req_op, res_ready,
    output req_ready, res_valid, res_tag, res_exp, res_man
  );
endinterface

// File: rtl/fma_issue_arbiter.sv
// ---------------------------------------------------------------------------
// fma_issue_arbiter
// Purpose : Round-robin arbiter sharing one combinational FMA datapath among
//           NREQ requesters. Granted operands are registered (S0) and drive
//           the datapath; its result is carried through LAT tagged result
//           stages and returned on a valid/ready port with full-pipeline
//           backpressure.
// Ports   : clk, rst          clock, asynchronous active-high reset
//           bus (slave)       request and result handshakes
//           dp_exp*/dp_man*   registered operands to the datapath
//           dp_expAns/dp_manAns  combinational datapath result
//           busy              any stage holds a valid entry
// Options : FMA_ISSUE_STATS_EN adds saturating 32-bit counters
//           stat_issued, stat_stall, stat_starve.
// ---------------------------------------------------------------------------
module fma_issue_arbiter #(
  parameter int NREQ = 4,
  parameter int LAT  = 2
) (
  input  logic                clk,
  input  logic                rst,
  fma_issue_arbiter_if.slave  bus,
  output logic [7:0]          dp_expA,
  output logic [7:0]          dp_expB,
  output logic [7:0]          dp_expC,
  output logic [23:0]         dp_manA,
  output logic [23:0]         dp_manB,
  output logic [23:0]         dp_manC,
  input  logic [7:0]          dp_expAns,
  input  logic [23:0]         dp_manAns,
  output logic                busy
`ifdef FMA_ISSUE_STATS_EN
  ,
  output logic [31:0]         stat_issued,
  output logic [31:0]         stat_stall,
  output logic [31:0]         stat_starve
`endif
);
  localparam int TW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic            stall;
  logic            accept;
  logic            lo_found, hi_found;
  logic [TW-1:0]   lo_idx, hi_idx, grant_idx;
  logic [TW-1:0]   ptr;
  logic [NREQ-1:0] ready_vec;
  logic [95:0]     sel_op;

  logic            s0_valid;
  logic [TW-1:0]   s0_tag;

  logic            stg_valid [1:LAT];
  logic [TW-1:0]   stg_tag   [1:LAT];
  logic [7:0]      stg_exp   [1:LAT];
  logic [23:0]     stg_man   [1:LAT];

  // A held result freezes the whole pipeline, bubbles included.
  assign stall = stg_valid[LAT] & ~bus.res_ready;

  // Round-robin pick: lowest valid index above ptr, else lowest valid index
  // overall (the wrap-around). The descending loop lets the lowest match win.
  always_comb begin
    lo_found = 1'b0;
    hi_found = 1'b0;
    lo_idx   = '0;
    hi_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        lo_found = 1'b1;
        lo_idx   = TW'(i);
        if (TW'(i) > ptr) begin
          hi_found = 1'b1;
          hi_idx   = TW'(i);
        end
      end
    end
    grant_idx = hi_found ? hi_idx : lo_idx;
  end

  // Grant is only ever given to a valid request, so grant implies accept.
  assign accept = lo_found & ~stall;

  // req_ready is also masked by rst so it drops the moment reset asserts.
  always_comb begin
    ready_vec = '0;
    sel_op    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == TW'(i)) begin
        ready_vec[i] = accept & ~rst;
        sel_op       = bus.req_op[96*i +: 96];
      end
    end
  end

  assign bus.req_ready = ready_vec;

  // S0 operand register and round-robin pointer. Without an accept the
  // operands hold, so the datapath inputs stay quiet during bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_valid <= 1'b0;
      s0_tag   <= '0;
      ptr      <= TW'(NREQ - 1);
      dp_expA  <= '0;
      dp_expB  <= '0;
      dp_expC  <= '0;
      dp_manA  <= '0;
      dp_manB  <= '0;
      dp_manC  <= '0;
    end else if (!stall) begin
      if (accept) begin
        s0_valid <= 1'b1;
        s0_tag   <= grant_idx;
        ptr      <= grant_idx;
        dp_expA  <= sel_op[95:88];
        dp_expB  <= sel_op[87:80];
        dp_expC  <= sel_op[79:72];
        dp_manA  <= sel_op[71:48];
        dp_manB  <= sel_op[47:24];
        dp_manC  <= sel_op[23:0];
      end else begin
        s0_valid <= 1'b0;
      end
    end
  end

  // Result stages S1..SLAT. Datapath outputs are only captured behind a
  // valid S0; later stages copy unconditionally with valid riding along.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 1; k <= LAT; k++) begin
        stg_valid[k] <= 1'b0;
        stg_tag[k]   <= '0;
        stg_exp[k]   <= '0;
        stg_man[k]   <= '0;
      end
    end else if (!stall) begin
      stg_valid[1] <= s0_valid;
      if (s0_valid) begin
        stg_tag[1] <= s0_tag;
        stg_exp[1] <= dp_expAns;
        stg_man[1] <= dp_manAns;
      end
      for (int k = 2; k <= LAT; k++) begin
        stg_valid[k] <= stg_valid[k-1];
        stg_tag[k]   <= stg_tag[k-1];
        stg_exp[k]   <= stg_exp[k-1];
        stg_man[k]   <= stg_man[k-1];
      end
    end
  end

  assign bus.res_valid = stg_valid[LAT];
  assign bus.res_tag   = stg_tag[LAT];
  assign bus.res_exp   = stg_exp[LAT];
  assign bus.res_man   = stg_man[LAT];

  always_comb begin
    busy = s0_valid;
    for (int k = 1; k <= LAT; k++) begin
      busy = busy | stg_valid[k];
    end
  end

`ifdef FMA_ISSUE_STATS_EN
  // Saturating event counters: each sticks at all-ones once reached.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_issued <= '0;
      stat_stall  <= '0;
      stat_starve <= '0;
    end else begin
      if (accept && (stat_issued != '1)) begin
        stat_issued <= stat_issued + 32'd1;
      end
      if (stall && (stat_stall != '1)) begin
        stat_stall <= stat_stall + 32'd1;
      end
      if ((|bus.req_valid) && !accept && (stat_starve != '1)) begin
        stat_starve <= stat_starve + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fma_issue_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fma_issue_arbiter
// Purpose : Self-checking bench for fma_issue_arbiter (NREQ=4, LAT=2) with a
//           stub datapath: exp = expA + expB, man = manA ^ manC.
//           A table of per-cycle vectors covers arbitration order and result
//           flow; hand-written sequences cover single request, round-robin,
//           backpressure, mid-flight reset and (with FMA_ISSUE_STATS_EN)
//           the statistics counters.
// ---------------------------------------------------------------------------
module tb_fma_issue_arbiter;
  localparam int NREQ = 4;
  localparam int LAT  = 2;

  logic        clk;
  logic        rst;
  logic [7:0]  dp_expA, dp_expB, dp_expC;
  logic [23:0] dp_manA, dp_manB, dp_manC;
  logic [7:0]  dp_expAns;
  logic [23:0] dp_manAns;
  logic        busy;
`ifdef FMA_ISSUE_STATS_EN
  logic [31:0] stat_issued, stat_stall, stat_starve;
`endif

  int total;
  int bad;

  fma_issue_arbiter_if #(.NREQ(NREQ)) bus ();

  fma_issue_arbiter #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dp_expA   (dp_expA),
    .dp_expB   (dp_expB),
    .dp_expC   (dp_expC),
    .dp_manA   (dp_manA),
    .dp_manB   (dp_manB),
    .dp_manC   (dp_manC),
    .dp_expAns (dp_expAns),
    .dp_manAns (dp_manAns),
    .busy      (busy)
`ifdef FMA_ISSUE_STATS_EN
    ,
    .stat_issued (stat_issued),
    .stat_stall  (stat_stall),
    .stat_starve (stat_starve)
`endif
  );

  // Stub datapath standing in for the real FMA.
  assign dp_expAns = dp_expA + dp_expB;
  assign dp_manAns = dp_manA ^ dp_manC;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-cycle vector: request pattern applied with res_ready=1, and the
  // grant and result expected on that same cycle.
  typedef struct {
    logic [3:0] rv;
    logic [3:0] expReady;
    logic       expValid;
    logic [1:0] expTag;
    logic [7:0] expExp;
  } vec_t;

  vec_t vecs [13];
  int   order [6];
  int   sbTag [$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] rv, input logic rr);
    bus.req_valid = rv;
    bus.res_ready = rr;
  endtask

  task automatic setOp(input int i, input logic [7:0] ea, input logic [7:0] eb, input logic [7:0] ec,
                       input logic [23:0] ma, input logic [23:0] mb, input logic [23:0] mc);
    bus.req_op[96*i +: 96] = {ea, eb, ec, ma, mb, mc};
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(4'b0000, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Requester i: expA=i+1, expB=0x10 -> result exp 0x11+i.
  task automatic setDefaultOps();
    for (int i = 0; i < NREQ; i++) begin
      setOp(i, 8'(i + 1), 8'h10, 8'h00, 24'h0A0000 + 24'(i), 24'h0, 24'h000F00);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    bus.req_op = '0;
    applyStimulus(4'b0000, 1'b1);

    vecs[0]  = '{4'b0000, 4'b0000, 1'b0, 2'd0, 8'h00};
    vecs[1]  = '{4'b0100, 4'b0100, 1'b0, 2'd0, 8'h00};
    vecs[2]  = '{4'b0101, 4'b0001, 1'b0, 2'd0, 8'h00};
    vecs[3]  = '{4'b0100, 4'b0100, 1'b0, 2'd0, 8'h00};
    vecs[4]  = '{4'b1111, 4'b1000, 1'b1, 2'd2, 8'h13};
    vecs[5]  = '{4'b1111, 4'b0001, 1'b1, 2'd0, 8'h11};
    vecs[6]  = '{4'b0110, 4'b0010, 1'b1, 2'd2, 8'h13};
    vecs[7]  = '{4'b1001, 4'b1000, 1'b1, 2'd3, 8'h14};
    vecs[8]  = '{4'b1000, 4'b1000, 1'b1, 2'd0, 8'h11};
    vecs[9]  = '{4'b0010, 4'b0010, 1'b1, 2'd1, 8'h12};
    vecs[10] = '{4'b0000, 4'b0000, 1'b1, 2'd3, 8'h14};
    vecs[11] = '{4'b0000, 4'b0000, 1'b1, 2'd3, 8'h14};
    vecs[12] = '{4'b0000, 4'b0000, 1'b1, 2'd1, 8'h12};
    order = '{0, 1, 2, 3, 0, 1};

    // ---- reset state ----
    doReset();
    @(negedge clk);
    checkOutput("rst_res_valid", 32'(bus.res_valid), 32'd0);
    checkOutput("rst_res_tag",   32'(bus.res_tag),   32'd0);
    checkOutput("rst_res_exp",   32'(bus.res_exp),   32'd0);
    checkOutput("rst_res_man",   32'(bus.res_man),   32'd0);
    checkOutput("rst_busy",      32'(busy),          32'd0);
    checkOutput("rst_dp_expA",   32'(dp_expA),       32'd0);
    checkOutput("rst_dp_manC",   32'(dp_manC),       32'd0);
    checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd0);

    // ---- table-driven arbitration and result flow ----
    doReset();
    setDefaultOps();
    for (int k = 0; k < 13; k++) begin
      applyStimulus(vecs[k].rv, 1'b1);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_req_ready", k), 32'(bus.req_ready), 32'(vecs[k].expReady));
      checkOutput($sformatf("vec%0d_res_valid", k), 32'(bus.res_valid), 32'(vecs[k].expValid));
      if (vecs[k].expValid) begin
        checkOutput($sformatf("vec%0d_res_tag", k), 32'(bus.res_tag), 32'(vecs[k].expTag));
        checkOutput($sformatf("vec%0d_res_exp", k), 32'(bus.res_exp), 32'(vecs[k].expExp));
      end
      nextCycle();
    end

    // ---- single request from requester 2 ----
    doReset();
    setOp(2, 8'd2, 8'd2, 8'd4, 24'h400000, 24'h400000, 24'h400000);
    applyStimulus(4'b0100, 1'b1);
    @(negedge clk);
    checkOutput("single_req_ready", 32'(bus.req_ready), 32'b0100);
    nextCycle();
    applyStimulus(4'b0000, 1'b1);
    @(negedge clk);
    checkOutput("single_dp_expA", 32'(dp_expA), 32'd2);
    checkOutput("single_valid_c1", 32'(bus.res_valid), 32'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("single_valid_c2", 32'(bus.res_valid), 32'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("single_valid_c3", 32'(bus.res_valid), 32'd1);
    checkOutput("single_tag", 32'(bus.res_tag), 32'd2);
    checkOutput("single_exp", 32'(bus.res_exp), 32'd4);
    checkOutput("single_man", 32'(bus.res_man), 32'h000000);
    nextCycle();
    @(negedge clk);
    checkOutput("single_busy_after", 32'(busy), 32'd0);
    checkOutput("single_valid_after", 32'(bus.res_valid), 32'd0);

    // ---- round-robin with all requesters held valid ----
    doReset();
    setDefaultOps();
    sbTag.delete();
    begin
      int got;
      got = 0;
      for (int c = 0; c < 14; c++) begin
        applyStimulus((c < 6) ? 4'b1111 : 4'b0000, 1'b1);
        @(negedge clk);
        if (c < 6) begin
          checkOutput($sformatf("rr_grant%0d", c), 32'(bus.req_ready), 32'(1) << order[c]);
          sbTag.push_back(order[c]);
        end
        if (bus.res_valid && bus.res_ready) begin
          if (sbTag.size() == 0) begin
            checkOutput("rr_unexpected_result", 32'(bus.res_valid), 32'd0);
          end else begin
            int t;
            t = sbTag.pop_front();
            checkOutput($sformatf("rr_res_tag%0d", got), 32'(bus.res_tag), 32'(t));
            checkOutput($sformatf("rr_res_exp%0d", got), 32'(bus.res_exp), 32'(8'h11 + 8'(t)));
            got++;
          end
        end
        nextCycle();
      end
      checkOutput("rr_result_count", 32'(got), 32'd6);
    end

    // ---- backpressure with 3 entries in flight ----
    doReset();
    setDefaultOps();
    applyStimulus(4'b0111, 1'b1);
    @(negedge clk);
    checkOutput("bp_grant0", 32'(bus.req_ready), 32'b0001);
    nextCycle();
    applyStimulus(4'b0110, 1'b1);
    @(negedge clk);
    checkOutput("bp_grant1", 32'(bus.req_ready), 32'b0010);
    nextCycle();
    applyStimulus(4'b0100, 1'b1);
    @(negedge clk);
    checkOutput("bp_grant2", 32'(bus.req_ready), 32'b0100);
    nextCycle();
    for (int c = 0; c < 5; c++) begin
      applyStimulus(4'b1000, 1'b0);
      @(negedge clk);
      checkOutput($sformatf("bp_hold%0d_valid", c), 32'(bus.res_valid), 32'd1);
      checkOutput($sformatf("bp_hold%0d_tag", c),   32'(bus.res_tag),   32'd0);
      checkOutput($sformatf("bp_hold%0d_exp", c),   32'(bus.res_exp),   32'h11);
      checkOutput($sformatf("bp_hold%0d_ready", c), 32'(bus.req_ready), 32'd0);
      checkOutput($sformatf("bp_hold%0d_dpA", c),   32'(dp_expA),       32'd3);
      nextCycle();
    end
    applyStimulus(4'b1000, 1'b1);
    @(negedge clk);
    checkOutput("bp_release_ready", 32'(bus.req_ready), 32'b1000);
    for (int c = 0; c < 4; c++) begin
      checkOutput($sformatf("bp_drain%0d_valid", c), 32'(bus.res_valid), 32'd1);
      checkOutput($sformatf("bp_drain%0d_tag", c),   32'(bus.res_tag),   32'(c));
      checkOutput($sformatf("bp_drain%0d_exp", c),   32'(bus.res_exp),   32'(8'h11 + 8'(c)));
      nextCycle();
      applyStimulus(4'b0000, 1'b1);
      @(negedge clk);
    end
    checkOutput("bp_idle_valid", 32'(bus.res_valid), 32'd0);
    checkOutput("bp_idle_busy",  32'(busy),          32'd0);

    // ---- asynchronous reset with 2 entries in flight ----
    doReset();
    setDefaultOps();
    applyStimulus(4'b0011, 1'b1);
    @(negedge clk);
    checkOutput("mr_grant0", 32'(bus.req_ready), 32'b0001);
    nextCycle();
    applyStimulus(4'b0010, 1'b1);
    @(negedge clk);
    checkOutput("mr_grant1", 32'(bus.req_ready), 32'b0010);
    nextCycle();
    applyStimulus(4'b0000, 1'b1);
    nextCycle();
    applyStimulus(4'b1100, 1'b1);
    @(negedge clk);
    checkOutput("mr_pre_valid", 32'(bus.res_valid), 32'd1);
    checkOutput("mr_pre_ready", 32'(bus.req_ready), 32'b0100);
    checkOutput("mr_pre_busy",  32'(busy),          32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mr_rst_valid", 32'(bus.res_valid), 32'd0);
    checkOutput("mr_rst_busy",  32'(busy),          32'd0);
    checkOutput("mr_rst_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("mr_first_grant", 32'(bus.req_ready), 32'b0100);
    nextCycle();
    applyStimulus(4'b0000, 1'b1);
    @(negedge clk);
    checkOutput("mr_no_replay0", 32'(bus.res_valid), 32'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("mr_no_replay1", 32'(bus.res_valid), 32'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("mr_new_valid", 32'(bus.res_valid), 32'd1);
    checkOutput("mr_new_tag",   32'(bus.res_tag),   32'd2);
    nextCycle();

`ifdef FMA_ISSUE_STATS_EN
    // ---- statistics counters ----
    doReset();
    setDefaultOps();
    for (int c = 0; c < 6; c++) begin
      applyStimulus(4'b1111, 1'b1);
      nextCycle();
    end
    for (int c = 0; c < 4; c++) begin
      applyStimulus(4'b0000, 1'b0);
      nextCycle();
    end
    applyStimulus(4'b0000, 1'b1);
    @(negedge clk);
    checkOutput("stat_issued", stat_issued, 32'd6);
    checkOutput("stat_stall",  stat_stall,  32'd4);
    checkOutput("stat_starve", stat_starve, 32'd0);
    repeat (4) nextCycle();
    force dut.stat_issued = 32'hFFFF_FFFF;
    #1;
    release dut.stat_issued;
    applyStimulus(4'b0001, 1'b1);
    @(negedge clk);
    checkOutput("stat_sat_ready", 32'(bus.req_ready), 32'b0001);
    nextCycle();
    applyStimulus(4'b0000, 1'b1);
    @(negedge clk);
    checkOutput("stat_issued_sat", stat_issued, 32'hFFFF_FFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
